octal_rr_arbiter: RTL and testbench

//   8-way round-robin arbiter; upstream stage of the octal-to-binary encoder.

---
 rtl/octal_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_octal_rr_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/octal_rr_arbiter.sv
// rtl/octal_rr_arbiter.sv - 8-way round-robin arbiter with registered one-hot grant
//
// Purpose: samples eight level request lines and issues a strictly one-hot
//   grant that feeds an octal-to-binary encoder. A grant is held until it is
//   acknowledged. Priority then rotates past the winner.
// Optional feature macro: OCTARB_TIMEOUT_EN adds a hold counter. With it, a
//   grant left unacknowledged for HOLD_MAX cycles is forcibly released.
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   req[7:0]     in   level requests, bit i = octal digit i
//   grant_ack    in   consumer done with current grant (used in GRANT only)
//   grant[7:0]   out  registered one-hot grant, zero when idle
//   grant_valid  out  high while a grant is active
//   ptr[2:0]     out  index of the most recent winner
//   timeout      out  one-cycle pulse on forced release (always 0 without macro)

module octal_rr_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       grant_ack,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic [2:0] ptr,
    output logic       timeout
);

    generate
        if (HOLD_MAX < 2 || (1 << CNT_W) <= HOLD_MAX) begin : g_bad_cfg
            $error("octal_rr_arbiter: need HOLD_MAX >= 2 and 2**CNT_W > HOLD_MAX");
        end
    endgenerate

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] grant_next;
    logic       grant_valid_next;
    logic [2:0] ptr_next;
    logic       timeout_next;

    // Round-robin pick: scan ptr+1, ptr+2, ... ptr+8 (the last step wraps
    // back onto ptr itself, so a lone repeat requester still wins).
    logic       found;
    logic [2:0] win;

    always_comb begin
        logic [2:0] idx;
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef OCTARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
`endif

    always_comb begin
        state_next   = state;
        grant_next   = grant;
        ptr_next     = ptr;
        timeout_next = 1'b0;
`ifdef OCTARB_TIMEOUT_EN
        cnt_next     = cnt;
`endif
        case (state)
            S_IDLE: begin
                if (found) begin
                    grant_next = 8'b1 << win;
                    ptr_next   = win;
                    state_next = S_GRANT;
`ifdef OCTARB_TIMEOUT_EN
                    cnt_next   = '0;
`endif
                end
            end
            S_GRANT: begin
                // Release wins over any request activity; the next
                // arbitration always happens from IDLE a cycle later.
                if (grant_ack) begin
                    grant_next = 8'h00;
                    state_next = S_IDLE;
                end
`ifdef OCTARB_TIMEOUT_EN
                else if (cnt == CNT_W'(HOLD_MAX - 1)) begin
                    grant_next   = 8'h00;
                    state_next   = S_IDLE;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
`endif
            end
            default: begin
                grant_next = 8'h00;
                state_next = S_IDLE;
            end
        endcase
        grant_valid_next = (state_next == S_GRANT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            grant       <= 8'h00;
            grant_valid <= 1'b0;
            ptr         <= 3'd7;
            timeout     <= 1'b0;
`ifdef OCTARB_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            grant_valid <= grant_valid_next;
            ptr         <= ptr_next;
            timeout     <= timeout_next;
`ifdef OCTARB_TIMEOUT_EN
            cnt         <= cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_octal_rr_arbiter.sv
// tb/tb_octal_rr_arbiter.sv - directed and random checks of octal_rr_arbiter against a reference model

module tb_octal_rr_arbiter;

    localparam int HOLD_MAX = 4;
    localparam int CNT_W    = 3;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       grant_ack;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] ptr;
    logic       timeout;

    octal_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant_ack  (grant_ack),
        .grant      (grant),
        .grant_valid(grant_valid),
        .ptr        (ptr),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: who was granted last, whether a grant is outstanding,
    // and how long it has been outstanding.
    bit         m_busy  = 0;
    int         m_last  = 7;
    int         m_held  = 0;
    bit         m_to    = 0;

    function automatic logic [7:0] model_grant();
        return m_busy ? (8'(1) << m_last) : 8'h00;
    endfunction

    function automatic int encode(input logic [7:0] g);
        int b = 0;
        for (int i = 0; i < 8; i++) if (g[i]) b = i;
        return b;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_update(input logic [7:0] r, input logic a, input logic rn);
        m_to = 0;
        if (!rn) begin
            m_busy = 0;
            m_last = 7;
            m_held = 0;
        end else if (!m_busy) begin
            for (int k = 1; k <= 8; k++) begin
                if (!m_busy && r[(m_last + k) % 8]) begin
                    m_last = (m_last + k) % 8;
                    m_busy = 1;
                    m_held = 1;
                end
            end
        end else if (a) begin
            m_busy = 0;
        end else begin
`ifdef OCTARB_TIMEOUT_EN
            if (m_held == HOLD_MAX) begin
                m_busy = 0;
                m_to   = 1;
            end else begin
                m_held++;
            end
`endif
        end
    endtask

    task automatic step(input logic [7:0] r, input logic a, input logic rn);
        req       = r;
        grant_ack = a;
        rst_n     = rn;
        @(posedge clk);
        model_update(r, a, rn);
        #1;
        check("grant", grant, model_grant());
        check("grant_valid", 8'(grant_valid), 8'(m_busy));
        check("ptr", 8'(ptr), 8'(m_last));
        check("timeout", 8'(timeout), 8'(m_to));
        check("onehot0", 8'($onehot0(grant)), 8'h01);
        if (grant_valid === 1'b1) check("encoder_b", 8'(encode(grant)), 8'(m_last));
    endtask

    initial begin
        req       = 8'h00;
        grant_ack = 1'b0;
        rst_n     = 1'b0;

        // Reset with all requests high
        for (int i = 0; i < 3; i++) begin
            step(8'hFF, 1'b0, 1'b0);
            check("rst_grant", grant, 8'h00);
            check("rst_ptr", 8'(ptr), 8'h07);
        end
        step(8'hFF, 1'b0, 1'b1);
        check("first_grant", grant, 8'h01);

        // Full rotation with wrap
        for (int i = 1; i <= 8; i++) begin
            step(8'hFF, 1'b1, 1'b1);
            check("rot_gap", grant, 8'h00);
            step(8'hFF, 1'b0, 1'b1);
            check("rot_grant", grant, 8'(1) << (i % 8));
        end
        step(8'hFF, 1'b1, 1'b1);

        // Sparse requests from ptr=2, wrap past 7
        step(8'h04, 1'b0, 1'b1);
        step(8'h04, 1'b1, 1'b1);
        step(8'h41, 1'b0, 1'b1);
        check("sparse_grant", grant, 8'h40);
        check("sparse_ptr", 8'(ptr), 8'h06);
        step(8'h41, 1'b1, 1'b1);
        step(8'h41, 1'b0, 1'b1);
        check("sparse_wrap", grant, 8'h01);
        step(8'h00, 1'b1, 1'b1);

        // Hold through request withdrawal
        step(8'h10, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(8'h00, 1'b0, 1'b1);
            check("hold_grant", grant, 8'h10);
        end
        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b1, 1'b1);
        check("idle_after_hold", grant, 8'h00);

        // Mid-grant reset
        step(8'h08, 1'b0, 1'b1);
        check("pre_rst_grant", grant, 8'h08);
        step(8'h08, 1'b0, 1'b0);
        check("midrst_grant", grant, 8'h00);
        check("midrst_ptr", 8'(ptr), 8'h07);
        step(8'h08, 1'b0, 1'b1);
        check("post_rst_grant", grant, 8'h08);
        step(8'h00, 1'b1, 1'b1);

        // Never-acknowledged grant
        step(8'h20, 1'b0, 1'b1);
        for (int i = 0; i < 110; i++) begin
            step(8'h20, 1'b0, 1'b1);
`ifndef OCTARB_TIMEOUT_EN
            check("persist_grant", grant, 8'h20);
`endif
        end
        step(8'h20, 1'b1, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom), ($urandom_range(2, 0) == 0), ($urandom_range(49, 0) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
